uci_bestmove_serializer: RTL and testbench
==========================================

Name: uci_bestmove_serializer

Overview:
- Converts one move_t from the search/move-selection path into the UCI text line "bestmove <move>" plus a terminator, emitted one byte per handshake.
- Sits downstream of move selection and feeds the UCI character output path, the same stream uci_handler drives on char_out.
- Single-entry buffer with an FSM. A new move is accepted only after the previous line has fully drained.

Parameters:
- TERMINATOR, 8'h0A: byte sent after the move text.
- EMIT_PREFIX, 1: 1 means send "bestmove " (9 bytes, including the trailing space) before the move; 0 means send the move text only.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-low
- move_in  input  $bits(move_t)  move to print; fields from_sq[5:0], to_sq[5:0], promo[2:0]
- move_in_valid  input  1  move_in is valid
- move_in_ready  output  1  block can accept a move
- char_out  output  8  ASCII byte
- char_out_valid  output  1  char_out is valid
- char_out_ready  input  1  sink accepts char_out
- busy_out  output  1  a line is in progress (captured and not yet fully sent)

Behaviour:
- Reset, asynchronous assert while rst_in=0:
  - state=IDLE, char_out_valid=0, char_out=8'h00, busy_out=0, move_in_ready=1 (once released).
  - Captured move and counters are cleared.
  - Any line in progress is abandoned; no further bytes are sent.
- Square encoding: sq = rank*8 + file, with a1=0 and h8=63.
  - File byte = 8'h61 + sq[2:0].
  - Rank byte = 8'h31 + sq[5:3].
- Promo code to character: 0 none; 1 'n'; 2 'b'; 3 'r'; 4 'q'. Codes 5..7 are treated as none.
- Null move (from_sq == to_sq) prints "0000", and promo is ignored.
- Move accept:
  - move_in_ready = (state == IDLE), taken directly from the state register.
  - On move_in_valid & move_in_ready the move is registered and state goes to PREFIX, or to MOVE when EMIT_PREFIX=0.
- Latency: the first byte is valid on the cycle after accept; there is no combinational path from input to output.
- FSM states: IDLE, PREFIX, MOVE, PROMO, EOL.
  - PREFIX: index 0..8 over "bestmove ". Goes to MOVE after index 8 is accepted.
  - MOVE: index 0..3 over from-file, from-rank, to-file, to-rank (or "0000" for a null move). Goes to PROMO if a promo character exists, else to EOL.
  - PROMO: one byte. Goes to EOL.
  - EOL: sends TERMINATOR. Goes to IDLE when accepted.
- Output handshake:
  - char_out and char_out_valid are registered.
  - While char_out_valid=1 and char_out_ready=0, char_out holds stable.
  - On char_out_valid & char_out_ready the next byte is presented the following cycle, so a continuously ready sink sees one byte per cycle with no bubbles.
- Drain to IDLE:
  - When TERMINATOR is accepted, the next cycle is IDLE with char_out_valid=0.
  - move_in_ready rises that same cycle. This costs one bubble between lines, and that bubble is by design.
- busy_out = (state != IDLE).
- move_in_valid while not ready: ignored and not latched. The upstream must hold it.
- Line length: 14 bytes for a normal move, 15 for a promotion. Subtract 9 when EMIT_PREFIX=0.
- Counters: 4-bit index, saturated by the state transitions, with no wrap beyond 8.

Decomposition:
- Shared types package (1_types.sv):
  - move_t (from_sq, to_sq, promo).
  - Promo code localparams PROMO_NONE/N/B/R/Q.
  - ASCII constants (CH_A_LOWER=8'h61, CH_ONE=8'h31, CH_ZERO=8'h30).
- Sub-module square_to_ascii: combinational, sq[5:0] -> {file_char, rank_char}. Used twice, for from_sq and to_sq.
- Prefix ROM: a local case on the index inside the top module.

Test Plan:
- from=12, to=28, promo=0, char_out_ready=1 -> "bestmove e2e4" then 8'h0A: 14 bytes on consecutive cycles; move_in_ready=0 throughout, back to 1 the cycle after the terminator.
- from=48, to=56, promo=4 -> "bestmove a7a8q\n" (15 bytes); promo=6 with the same squares -> "bestmove a7a8\n".
- from=0, to=0, promo=3 -> "bestmove 0000\n"; EMIT_PREFIX=0 with from=63, to=54 -> "h8g7\n" (5 bytes).
- Random char_out_ready (50% duty) on e2e4 -> identical 14-byte sequence with no drops or duplicates; char_out stable on every stalled cycle.
- rst_in pulsed low after the 5th byte -> char_out_valid=0 asynchronously; after release, move_in_ready=1; a new move g1f3 streams as a complete fresh line.
- Two moves presented back-to-back with move_in_valid held high -> the second is accepted only on the IDLE cycle after the first line's terminator; the output is two complete, ordered lines.

Source files
------------

// File: rtl/uci_bestmove_serializer_pkg.sv
// Shared types and ASCII constants for the UCI bestmove serializer.
// Holds the move record, promotion codes, FSM states and the promotion-letter lookup.
package uci_bestmove_serializer_pkg;

    typedef struct packed {
        logic [5:0] from_sq;
        logic [5:0] to_sq;
        logic [2:0] promo;
    } move_t;

    localparam logic [2:0] PROMO_NONE = 3'd0;
    localparam logic [2:0] PROMO_N    = 3'd1;
    localparam logic [2:0] PROMO_B    = 3'd2;
    localparam logic [2:0] PROMO_R    = 3'd3;
    localparam logic [2:0] PROMO_Q    = 3'd4;

    localparam logic [7:0] CH_A_LOWER = 8'h61;
    localparam logic [7:0] CH_ONE     = 8'h31;
    localparam logic [7:0] CH_ZERO    = 8'h30;

    typedef enum logic [2:0] {
        IDLE,
        PREFIX,
        MOVE,
        PROMO,
        EOL
    } state_t;

    // Codes outside 1..4 map to 8'h00, which callers read as "no promotion letter".
    function automatic logic [7:0] promo_char(input logic [2:0] code);
        logic [7:0] ch;
        ch = 8'h00;
        case (code)
            PROMO_N: ch = 8'h6E;
            PROMO_B: ch = 8'h62;
            PROMO_R: ch = 8'h72;
            PROMO_Q: ch = 8'h71;
            default: ch = 8'h00;
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/uci_bestmove_serializer_square_to_ascii.sv
// Square index (rank*8 + file, a1 = 0) to its two-character algebraic name.
module square_to_ascii
    import uci_bestmove_serializer_pkg::*;
(
    input  logic [5:0] sq,
    output logic [7:0] file_char,
    output logic [7:0] rank_char
);

    assign file_char = CH_A_LOWER + {5'd0, sq[2:0]};
    assign rank_char = CH_ONE + {5'd0, sq[5:3]};

endmodule

// File: rtl/uci_bestmove_serializer.sv
// Serializes one move into "bestmove <move>" plus a terminator, one byte per handshake.
// Bytes are precomputed for the next (state, index) so char_out is a plain register.
module uci_bestmove_serializer
    import uci_bestmove_serializer_pkg::*;
#(
    parameter logic [7:0] TERMINATOR  = 8'h0A,
    parameter bit         EMIT_PREFIX = 1'b1
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  move_t      move_in,
    input  logic       move_in_valid,
    output logic       move_in_ready,
    output logic [7:0] char_out,
    output logic       char_out_valid,
    input  logic       char_out_ready,
    output logic       busy_out
);

    state_t     state, next_state;
    logic [3:0] idx, next_idx;
    move_t      mv_q, mv_next;
    logic       accept, advance, load;
    logic       is_null, has_promo;
    logic [7:0] next_char, prefix_char, promo_ch;
    logic [7:0] from_file, from_rank, to_file, to_rank;

    assign move_in_ready = (state == IDLE);
    assign busy_out      = (state != IDLE);
    assign accept        = move_in_valid & move_in_ready;
    assign advance       = char_out_valid & char_out_ready;

    // The byte loaded on accept must come from the incoming move, not the stale capture.
    assign mv_next   = accept ? move_in : mv_q;
    assign is_null   = (mv_next.from_sq == mv_next.to_sq);
    assign promo_ch  = promo_char(mv_next.promo);
    assign has_promo = !is_null && (promo_ch != 8'h00);

    square_to_ascii u_from (
        .sq        (mv_next.from_sq),
        .file_char (from_file),
        .rank_char (from_rank)
    );

    square_to_ascii u_to (
        .sq        (mv_next.to_sq),
        .file_char (to_file),
        .rank_char (to_rank)
    );

    always_comb begin
        next_state = state;
        next_idx   = idx;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (move_in_valid) begin
                    next_state = EMIT_PREFIX ? PREFIX : MOVE;
                    next_idx   = 4'd0;
                    load       = 1'b1;
                end
            end
            PREFIX: begin
                if (advance) begin
                    load = 1'b1;
                    if (idx == 4'd8) begin
                        next_state = MOVE;
                        next_idx   = 4'd0;
                    end else begin
                        next_idx = idx + 4'd1;
                    end
                end
            end
            MOVE: begin
                if (advance) begin
                    load = 1'b1;
                    if (idx == 4'd3) begin
                        next_state = has_promo ? PROMO : EOL;
                        next_idx   = 4'd0;
                    end else begin
                        next_idx = idx + 4'd1;
                    end
                end
            end
            PROMO: begin
                if (advance) begin
                    load       = 1'b1;
                    next_state = EOL;
                end
            end
            EOL: begin
                if (advance) begin
                    load       = 1'b1;
                    next_state = IDLE;
                    next_idx   = 4'd0;
                end
            end
            default: begin
                next_state = IDLE;
                next_idx   = 4'd0;
            end
        endcase
    end

    always_comb begin
        prefix_char = 8'h00;
        case (next_idx)
            4'd0:    prefix_char = 8'h62;
            4'd1:    prefix_char = 8'h65;
            4'd2:    prefix_char = 8'h73;
            4'd3:    prefix_char = 8'h74;
            4'd4:    prefix_char = 8'h6D;
            4'd5:    prefix_char = 8'h6F;
            4'd6:    prefix_char = 8'h76;
            4'd7:    prefix_char = 8'h65;
            4'd8:    prefix_char = 8'h20;
            default: prefix_char = 8'h00;
        endcase
    end

    always_comb begin
        next_char = 8'h00;
        case (next_state)
            PREFIX: next_char = prefix_char;
            MOVE: begin
                if (is_null) begin
                    next_char = CH_ZERO;
                end else begin
                    case (next_idx[1:0])
                        2'd0:    next_char = from_file;
                        2'd1:    next_char = from_rank;
                        2'd2:    next_char = to_file;
                        default: next_char = to_rank;
                    endcase
                end
            end
            PROMO:   next_char = promo_ch;
            EOL:     next_char = TERMINATOR;
            default: next_char = 8'h00;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state          <= IDLE;
            idx            <= 4'd0;
            mv_q           <= '0;
            char_out       <= 8'h00;
            char_out_valid <= 1'b0;
        end else begin
            state <= next_state;
            idx   <= next_idx;
            if (accept) begin
                mv_q <= move_in;
            end
            if (load) begin
                char_out       <= next_char;
                char_out_valid <= (next_state != IDLE);
            end
        end
    end

endmodule

// File: tb/tb_uci_bestmove_serializer.sv
// Self-checking bench: directed and random moves against a string-level model of the UCI line.
module tb_uci_bestmove_serializer;
    import uci_bestmove_serializer_pkg::*;

    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       rst_n;
    move_t      move_in;
    logic       mv_valid0, mv_valid1;
    logic       char_out_ready;
    logic       mready0, cvalid0, busy0;
    logic       mready1, cvalid1, busy1;
    logic [7:0] char0, char1;
    bit         sel;
    logic       obs_valid, obs_mready, obs_busy;
    logic [7:0] obs_char;
    int         compare_count = 0;
    int         fail_count = 0;

    always #5 clk = ~clk;

    uci_bestmove_serializer #(.TERMINATOR(8'h0A), .EMIT_PREFIX(1'b1)) dut_prefix (
        .clk_in         (clk),
        .rst_in         (rst_n),
        .move_in        (move_in),
        .move_in_valid  (mv_valid0),
        .move_in_ready  (mready0),
        .char_out       (char0),
        .char_out_valid (cvalid0),
        .char_out_ready (char_out_ready),
        .busy_out       (busy0)
    );

    uci_bestmove_serializer #(.TERMINATOR(8'h0A), .EMIT_PREFIX(1'b0)) dut_bare (
        .clk_in         (clk),
        .rst_in         (rst_n),
        .move_in        (move_in),
        .move_in_valid  (mv_valid1),
        .move_in_ready  (mready1),
        .char_out       (char1),
        .char_out_valid (cvalid1),
        .char_out_ready (char_out_ready),
        .busy_out       (busy1)
    );

    assign obs_valid  = sel ? cvalid1 : cvalid0;
    assign obs_mready = sel ? mready1 : mready0;
    assign obs_busy   = sel ? busy1   : busy0;
    assign obs_char   = sel ? char1   : char0;

    function automatic move_t mk(input int from, input int to, input int promo);
        move_t m;
        m.from_sq = 6'(from);
        m.to_sq   = 6'(to);
        m.promo   = 3'(promo);
        return m;
    endfunction

    // Expected line built from the text rules: optional prefix, algebraic squares or "0000", promo letter, newline.
    function automatic byte_q_t model_line(input move_t m, input bit prefix);
        byte_q_t q;
        string   pre    = "bestmove ";
        string   files  = "abcdefgh";
        string   ranks  = "12345678";
        string   promos = "nbrq";
        int      f      = int'(m.from_sq);
        int      t      = int'(m.to_sq);
        int      p      = int'(m.promo);
        if (prefix) begin
            for (int i = 0; i < pre.len(); i++) q.push_back(pre[i]);
        end
        if (f == t) begin
            repeat (4) q.push_back(8'h30);
        end else begin
            q.push_back(files[f % 8]);
            q.push_back(ranks[f / 8]);
            q.push_back(files[t % 8]);
            q.push_back(ranks[t / 8]);
            if (p >= 1 && p <= 4) q.push_back(promos[p - 1]);
        end
        q.push_back(8'h0A);
        return q;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compare_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with the target DUT idle; returns at the falling edge after accept.
    task automatic applyStimulus(input move_t m, input bit which, input bit hold);
        sel     = which;
        move_in = m;
        if (which) mv_valid1 = 1'b1;
        else       mv_valid0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) begin
            mv_valid0 = 1'b0;
            mv_valid1 = 1'b0;
        end
        checkOutput("first_byte_latency", {31'd0, obs_valid}, 32'd1);
    endtask

    task automatic drainLine(input byte_q_t exp, input bit rand_ready, input int stop_after,
                             input bit check_drain);
        int         k       = 0;
        int         cycles  = 0;
        bit         stalled = 1'b0;
        logic [7:0] held    = 8'h00;
        logic       rdy;
        while (k < stop_after && cycles < 400) begin
            if (stalled) begin
                checkOutput("stall_valid", {31'd0, obs_valid}, 32'd1);
                checkOutput("stall_hold", {24'd0, obs_char}, {24'd0, held});
            end
            rdy            = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            char_out_ready = rdy;
            stalled        = 1'b0;
            if (obs_valid) begin
                checkOutput("busy_in_line", {31'd0, obs_busy}, 32'd1);
                checkOutput("mready_in_line", {31'd0, obs_mready}, 32'd0);
                if (rdy) begin
                    checkOutput($sformatf("byte%0d", k), {24'd0, obs_char}, {24'd0, exp[k]});
                    k++;
                end else begin
                    stalled = 1'b1;
                    held    = obs_char;
                end
            end
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end
        char_out_ready = 1'b1;
        if (k < stop_after) begin
            compare_count++;
            fail_count++;
            $error("[TB] FAIL line_timeout observed=%0d bytes expected=%0d bytes", k, stop_after);
        end
        if (!rand_ready) checkOutput("no_bubbles", 32'(cycles), 32'(stop_after));
        if (check_drain) begin
            checkOutput("drain_valid", {31'd0, obs_valid}, 32'd0);
            checkOutput("drain_mready", {31'd0, obs_mready}, 32'd1);
        end
    endtask

    task automatic runLine(input move_t m, input bit which, input bit rand_ready);
        byte_q_t exp;
        exp = model_line(m, !which);
        applyStimulus(m, which, 1'b0);
        drainLine(exp, rand_ready, exp.size(), 1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    initial begin
        move_t   m, m2;
        byte_q_t exp;
        int      from, to;

        rst_n          = 1'b0;
        mv_valid0      = 1'b0;
        mv_valid1      = 1'b0;
        char_out_ready = 1'b1;
        move_in        = '0;
        sel            = 1'b0;

        #2;
        checkOutput("reset_valid", {31'd0, cvalid0}, 32'd0);
        checkOutput("reset_char", {24'd0, char0}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy0}, 32'd0);
        checkOutput("reset_valid_bare", {31'd0, cvalid1}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_mready", {31'd0, mready0}, 32'd1);
        checkOutput("post_reset_mready_bare", {31'd0, mready1}, 32'd1);

        $display("[TB] directed lines");
        runLine(mk(12, 28, 0), 1'b0, 1'b0);
        runLine(mk(48, 56, 4), 1'b0, 1'b0);
        runLine(mk(48, 56, 6), 1'b0, 1'b0);
        runLine(mk(0, 0, 3), 1'b0, 1'b0);
        runLine(mk(63, 54, 0), 1'b1, 1'b0);
        runLine(mk(12, 28, 0), 1'b0, 1'b1);

        $display("[TB] random lines");
        for (int i = 0; i < 10; i++) begin
            from = $urandom_range(0, 63);
            to   = ($urandom_range(0, 7) == 0) ? from : $urandom_range(0, 63);
            runLine(mk(from, to, $urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
        end

        $display("[TB] reset mid-line");
        m   = mk(12, 28, 0);
        exp = model_line(m, 1'b1);
        applyStimulus(m, 1'b0, 1'b0);
        drainLine(exp, 1'b0, 5, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", {31'd0, cvalid0}, 32'd0);
        checkOutput("async_reset_char", {24'd0, char0}, 32'd0);
        checkOutput("async_reset_busy", {31'd0, busy0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_release_mready", {31'd0, mready0}, 32'd1);
        checkOutput("reset_release_valid", {31'd0, cvalid0}, 32'd0);
        runLine(mk(6, 21, 0), 1'b0, 1'b0);

        $display("[TB] back-to-back moves");
        m   = mk(1, 18, 0);
        m2  = mk(52, 60, 2);
        exp = model_line(m, 1'b1);
        applyStimulus(m, 1'b0, 1'b1);
        move_in = m2;
        drainLine(exp, 1'b0, exp.size(), 1'b1);
        @(posedge clk);
        @(negedge clk);
        mv_valid0 = 1'b0;
        checkOutput("second_line_latency", {31'd0, cvalid0}, 32'd1);
        exp = model_line(m2, 1'b1);
        drainLine(exp, 1'b0, exp.size(), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
